// File: rtl/video_pattern_gen_if.sv
// Pixel-side bus between video_driver and video_pattern_gen.
// The master drives coordinates and controls; the slave returns colour and timing.
interface video_pattern_gen_if #(
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9,
    parameter int unsigned COLOR_BITS = 8
);
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic                    pix_en;
    logic [1:0]              mode;
    logic [3*COLOR_BITS-1:0] color;
    logic                    pause;
    logic [COLOR_BITS-1:0]   r;
    logic [COLOR_BITS-1:0]   g;
    logic [COLOR_BITS-1:0]   b;
    logic                    pix_valid;
    logic                    frame_start;
    logic [XW-1:0]           scroll;

    modport master (
        output x, y, pix_en, mode, color, pause,
        input  r, g, b, pix_valid, frame_start, scroll
    );

    modport slave (
        input  x, y, pix_en, mode, color, pause,
        output r, g, b, pix_valid, frame_start, scroll
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Per-pixel colour generator: four frame-synchronous patterns with a per-frame
// horizontal scroll, rendered through a fixed two-stage pipeline.
module video_pattern_gen #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned COLOR_BITS  = 8,
    parameter int unsigned CHECK_LOG2  = 5,
    parameter int unsigned SCROLL_STEP = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    video_pattern_gen_if.slave vif
);
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned C  = COLOR_BITS;
    localparam int unsigned CW = 3 * COLOR_BITS;

    localparam logic [1:0] MODE_SOLID    = 2'd0;
    localparam logic [1:0] MODE_GRADIENT = 2'd1;
    localparam logic [1:0] MODE_CHECKER  = 2'd2;
    localparam logic [1:0] MODE_BARS     = 2'd3;

    // Frame-latched rendering state and scroll offset
    logic [1:0]    r_mode_a;
    logic [CW-1:0] r_color_a;
    logic [XW-1:0] r_scroll;

    // Stage 1
    logic          r_s1_valid;
    logic          r_s1_active;
    logic          r_s1_fs;
    logic [XW-1:0] r_s1_xs;
    logic [YW-1:0] r_s1_y;

    // Stage 2 (outputs)
    logic [C-1:0]  r_r;
    logic [C-1:0]  r_g;
    logic [C-1:0]  r_b;
    logic          r_pix_valid;
    logic          r_frame_start;

    logic          w_fs;
    logic          w_in_area;
    logic [XW:0]   w_xsum;
    logic [XW-1:0] w_xs;
    logic [XW:0]   w_ssum;
    logic [XW-1:0] w_scroll_nxt;
    logic [2:0]    w_k;
    logic [C-1:0]  w_r;
    logic [C-1:0]  w_g;
    logic [C-1:0]  w_b;

    assign w_fs      = vif.pix_en && (vif.x == '0) && (vif.y == '0);
    assign w_in_area = ({1'b0, vif.x} < (XW+1)'(WIDTH)) && ({1'b0, vif.y} < (YW+1)'(HEIGHT));

    // Scrolled column, wrapped into 0..WIDTH-1 (only meaningful inside the active area)
    assign w_xsum = {1'b0, vif.x} + {1'b0, r_scroll};
    assign w_xs   = (w_xsum >= (XW+1)'(WIDTH)) ? XW'(w_xsum - (XW+1)'(WIDTH)) : XW'(w_xsum);

    assign w_ssum       = {1'b0, r_scroll} + (XW+1)'(SCROLL_STEP);
    assign w_scroll_nxt = (w_ssum >= (XW+1)'(WIDTH)) ? XW'(w_ssum - (XW+1)'(WIDTH)) : XW'(w_ssum);

    // Frame-start latch of mode/colour, and scroll advance unless paused
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_mode_a  <= MODE_SOLID;
            r_color_a <= '0;
            r_scroll  <= '0;
        end else if (w_fs) begin
            r_mode_a  <= vif.mode;
            r_color_a <= vif.color;
            if (!vif.pause) begin
                r_scroll <= w_scroll_nxt;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_active <= 1'b0;
            r_s1_fs     <= 1'b0;
            r_s1_xs     <= '0;
            r_s1_y      <= '0;
        end else begin
            r_s1_valid  <= vif.pix_en;
            r_s1_active <= vif.pix_en && w_in_area;
            r_s1_fs     <= w_fs;
            r_s1_xs     <= w_xs;
            r_s1_y      <= vif.y;
        end
    end

    assign w_k = r_s1_xs[XW-1 -: 3];

    // Colour lookup; mode_a has already been updated when the frame-start pixel sits here
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (r_s1_active) begin
            case (r_mode_a)
                MODE_SOLID: begin
                    {w_r, w_g, w_b} = r_color_a;
                end
                MODE_GRADIENT: begin
                    w_r = r_s1_xs[XW-1 -: C];
                    w_g = r_s1_y[YW-1 -: C];
                    w_b = ~r_s1_xs[XW-1 -: C];
                end
                MODE_CHECKER: begin
                    if (r_s1_xs[CHECK_LOG2] ^ r_s1_y[CHECK_LOG2]) begin
                        {w_r, w_g, w_b} = r_color_a;
                    end
                end
                MODE_BARS: begin
                    w_r = {C{w_k[2]}};
                    w_g = {C{w_k[1]}};
                    w_b = {C{w_k[0]}};
                end
                default: begin
                    w_r = '0;
                    w_g = '0;
                    w_b = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_r           <= w_r;
            r_g           <= w_g;
            r_b           <= w_b;
            r_pix_valid   <= r_s1_valid;
            r_frame_start <= r_s1_fs;
        end
    end

    assign vif.r           = r_r;
    assign vif.g           = r_g;
    assign vif.b           = r_b;
    assign vif.pix_valid   = r_pix_valid;
    assign vif.frame_start = r_frame_start;
    assign vif.scroll      = r_scroll;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomised bench for video_pattern_gen against a frame-level behavioural model,
// plus directed boundary scenarios with hand-derived expected colours.
module tb_video_pattern_gen;
    localparam int unsigned WIDTH  = 640;
    localparam int unsigned HEIGHT = 480;
    localparam int unsigned C      = 8;
    localparam int unsigned CHK    = 5;
    localparam int unsigned STEP   = 1;
    localparam int unsigned XW     = 10;
    localparam int unsigned YW     = 9;

    typedef struct packed {
        logic [23:0] rgb;
        logic        v;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    int          m_mode;
    logic [23:0] m_color;
    int          m_scroll;
    exp_t        q[$];

    always #5 clk = ~clk;

    video_pattern_gen_if #(.XW(XW), .YW(YW), .COLOR_BITS(C)) vif ();

    video_pattern_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLOR_BITS(C),
        .CHECK_LOG2(CHK), .SCROLL_STEP(STEP)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .vif(vif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] full(input int bitv);
        return (bitv != 0) ? 8'hFF : 8'h00;
    endfunction

    task automatic model_reset();
        exp_t z;
        z = '0;
        m_mode   = 0;
        m_color  = '0;
        m_scroll = 0;
        q.delete();
        q.push_back(z);
    endtask

    // One clock: drive a pixel, predict its result, then check what the pipeline shows now
    task automatic drive(input int x, input int y, input bit en, input int mode,
                         input logic [23:0] color, input bit pause);
        exp_t e;
        bit   fs;
        int   xs;
        int   k;
        logic [7:0] er;
        logic [7:0] eg;
        vif.x      = XW'(x);
        vif.y      = YW'(y);
        vif.pix_en = en;
        vif.mode   = 2'(mode);
        vif.color  = color;
        vif.pause  = pause;
        fs = en && (x == 0) && (y == 0);
        if (fs) begin
            m_mode  = mode;
            m_color = color;
        end
        e = '0;
        if (en) begin
            e.v  = 1'b1;
            e.fs = fs;
            if (x < WIDTH && y < HEIGHT) begin
                xs = (x + m_scroll) % WIDTH;
                case (m_mode)
                    0: e.rgb = m_color;
                    1: begin
                        er = 8'(xs / (1 << (XW - C)));
                        eg = 8'(y / (1 << (YW - C)));
                        e.rgb = {er, eg, 8'(255 - int'(er))};
                    end
                    2: e.rgb = ((((xs >> CHK) + (y >> CHK)) % 2) == 1) ? m_color : 24'h0;
                    default: begin
                        k = xs / (1 << (XW - 3));
                        e.rgb = {full(k & 4), full(k & 2), full(k & 1)};
                    end
                endcase
            end
        end
        if (fs && !pause) m_scroll = (m_scroll + STEP) % WIDTH;
        q.push_back(e);
        @(posedge clk);
        #1;
        chk("scroll", 32'(vif.scroll), 32'(m_scroll));
        e = q.pop_front();
        chk("rgb", {8'h0, vif.r, vif.g, vif.b}, {8'h0, e.rgb});
        chk("pix_valid", 32'(vif.pix_valid), 32'(e.v));
        chk("frame_start", 32'(vif.frame_start), 32'(e.fs));
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 0, 24'h0, 1'b0);
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, {vif.r, vif.g, vif.b, vif.pix_valid, vif.frame_start, 6'h0},
            32'h0);
        chk({tag, "_scroll"}, 32'(vif.scroll), 32'h0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        vif.x = '0; vif.y = '0; vif.pix_en = 1'b0;
        vif.mode = '0; vif.color = '0; vif.pause = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs_zero("reset_state");
        rst = 1'b0;
        model_reset();
    endtask

    // Asynchronous reset between edges: outputs must clear before any clock
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        outs_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int sel;
        int x;
        int y;
        vif.x = '0; vif.y = '0; vif.pix_en = 1'b0;
        vif.mode = '0; vif.color = '0; vif.pause = 1'b0;
        reset_dut();

        // Pixels before any frame start are black but valid
        drive(5, 5, 1, 1, 24'hFFFFFF, 0);
        drive(6, 5, 1, 1, 24'hFFFFFF, 0);
        drive(7, 5, 1, 1, 24'hFFFFFF, 0);
        idle();
        chk("pre_frame_valid", 32'(vif.pix_valid), 32'd1);
        chk("pre_frame_black", {8'h0, vif.r, vif.g, vif.b}, 32'h0);

        // SOLID latched at (0,0)
        drive(0, 0, 1, 0, 24'hFF8000, 0);
        drive(5, 7, 1, 2, 24'h000000, 0);
        chk("solid_fs", 32'(vif.frame_start), 32'd1);
        chk("solid_00", {8'h0, vif.r, vif.g, vif.b}, 32'hFF8000);
        idle();
        chk("solid_57", {8'h0, vif.r, vif.g, vif.b}, 32'hFF8000);

        // GRADIENT corner and scroll wrap of the scrolled column
        reset_dut();
        drive(0, 0, 1, 1, 24'h0, 1);
        drive(639, 479, 1, 0, 24'h0, 0);
        idle();
        chk("grad_corner", {8'h0, vif.r, vif.g, vif.b}, 32'h9FEF60);
        drive(0, 0, 1, 1, 24'h0, 0);
        drive(639, 0, 1, 0, 24'h0, 0);
        idle();
        chk("grad_xs0", {8'h0, vif.r, vif.g, vif.b}, 32'h0000FF);

        // BARS stays active after a mid-frame mode change (scroll=1, xs=321, k=2)
        drive(0, 0, 1, 3, 24'h0, 1);
        drive(320, 100, 1, 0, 24'hABCDEF, 0);
        idle();
        chk("bars_midframe", {8'h0, vif.r, vif.g, vif.b}, 32'h00FF00);
        drive(0, 0, 1, 0, 24'h123456, 1);
        drive(10, 10, 1, 3, 24'h0, 0);
        idle();
        chk("solid_next_frame", {8'h0, vif.r, vif.g, vif.b}, 32'h123456);

        // Scroll wrap and pause
        reset_dut();
        for (int i = 0; i < 639; i++) drive(0, 0, 1, 3, 24'h0, 0);
        chk("scroll_639", 32'(vif.scroll), 32'd639);
        drive(0, 0, 1, 2, 24'h00FF00, 1);
        chk("scroll_paused", 32'(vif.scroll), 32'd639);
        drive(0, 0, 1, 2, 24'h00FF00, 0);
        chk("scroll_wrap", 32'(vif.scroll), 32'd0);

        // CHECKER cells at scroll 0
        drive(32, 0, 1, 0, 24'h0, 0);
        drive(32, 32, 1, 0, 24'h0, 0);
        chk("check_on", {8'h0, vif.r, vif.g, vif.b}, 32'h00FF00);
        idle();
        chk("check_off", {8'h0, vif.r, vif.g, vif.b}, 32'h0);

        // Out-of-area pixels are black but valid
        drive(700, 10, 1, 0, 24'h0, 0);
        drive(10, 500, 1, 0, 24'h0, 0);
        chk("oob_x_valid", 32'(vif.pix_valid), 32'd1);
        chk("oob_x_black", {8'h0, vif.r, vif.g, vif.b}, 32'h0);

        // Randomised traffic with occasional asynchronous resets
        for (int n = 0; n < 4000; n++) begin
            sel = int'($urandom_range(0, 15));
            if (sel < 2) begin
                x = 0; y = 0;
            end else if (sel == 2) begin
                x = int'($urandom_range(640, 1023)); y = int'($urandom_range(0, 511));
            end else if (sel == 3) begin
                x = int'($urandom_range(0, 639)); y = int'($urandom_range(480, 511));
            end else begin
                x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479));
            end
            drive(x, y, $urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
                  24'($urandom), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) mid_reset();
        end
        mid_reset();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
